// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the memory-stage access sequencer (master)
// and the data bus / memory system (slave).
interface mem_access_ctrl_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus sequencer: takes one load/store from the MEM stage,
// runs the dreq/dresp handshake, stalls the pipeline while the access is in
// flight and returns an aligned, extended load word on completion.
module mem_access_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_we,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  output logic              stall,
  output logic              m_done,
  output logic              misalign,
  output logic [31:0]       load_data,
  mem_access_ctrl_if.master dbus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_next;

  // Request registers: the op is frozen here once it leaves IDLE.
  logic        req_we;
  logic        req_unsigned;
  logic [1:0]  req_size;
  logic [1:0]  req_lane;

  logic        addr_aligned;
  logic        accept;
  logic        capture;
  logic [3:0]  st_strobe;
  logic [31:0] st_data;

  // Picks the addressed byte/half out of the raw bus word and extends it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    extend_load = {{24{b[7] & ~uns}}, b};
      2'd1:    extend_load = {{16{h[15] & ~uns}}, h};
      default: extend_load = word;
    endcase
  endfunction

  // Alignment of the incoming address for its size; size 3 behaves as word.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    addr_aligned = 1'b1;
    case (m_size)
      2'd0:    addr_aligned = 1'b1;
      2'd1:    addr_aligned = ~m_addr[0];
      default: addr_aligned = (m_addr[1:0] == 2'b00);
    endcase
  end

  // Byte strobes and lane-replicated store data for the incoming op.
  always_comb begin
    st_strobe = 4'b0000;
    st_data   = m_wdata;
    case (m_size)
      2'd0: begin
        st_strobe = 4'b0001 << m_addr[1:0];
        st_data   = {4{m_wdata[7:0]}};
      end
      2'd1: begin
        st_strobe = 4'b0011 << {m_addr[1], 1'b0};
        st_data   = {2{m_wdata[15:0]}};
      end
      default: begin
        st_strobe = 4'b1111;
        st_data   = m_wdata;
      end
    endcase
    if (!m_we) st_strobe = 4'b0000;
  end

  // Next-state logic plus the combinational pipeline-facing outputs.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    m_done     = 1'b0;
    misalign   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (m_valid) begin
          if (addr_aligned) begin
            accept     = 1'b1;
            stall      = 1'b1;
            state_next = S_REQ;
          end else begin
            // Misaligned ops retire immediately without touching the bus.
            m_done   = 1'b1;
            misalign = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            capture    = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dbus.dresp_data_ok) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        m_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Reset silences the pipeline-facing strobes in the same cycle.
    if (reset) begin
      stall    = 1'b0;
      m_done   = 1'b0;
      misalign = 1'b0;
      accept   = 1'b0;
      capture  = 1'b0;
    end
  end

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Request latch, registered bus request and the captured load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we           <= 1'b0;
      req_unsigned     <= 1'b0;
      req_size         <= 2'd0;
      req_lane         <= 2'd0;
      dbus.dreq_valid  <= 1'b0;
      dbus.dreq_addr   <= 32'd0;
      dbus.dreq_size   <= 2'd0;
      dbus.dreq_strobe <= 4'd0;
      dbus.dreq_data   <= 32'd0;
      load_data        <= 32'd0;
    end else begin
      if (accept) begin
        req_we           <= m_we;
        req_unsigned     <= m_unsigned;
        req_size         <= m_size;
        req_lane         <= m_addr[1:0];
        dbus.dreq_valid  <= 1'b1;
        dbus.dreq_addr   <= {m_addr[31:2], 2'b00};
        dbus.dreq_size   <= m_size;
        dbus.dreq_strobe <= st_strobe;
        dbus.dreq_data   <= st_data;
      end else if (state == S_REQ && dbus.dresp_addr_ok) begin
        // The request is held stable until the bus accepts it.
        dbus.dreq_valid <= 1'b0;
      end
      if (capture) begin
        load_data <= req_we ? 32'd0
                            : extend_load(dbus.dresp_data, req_size, req_unsigned, req_lane);
      end
    end
  end

endmodule
